adder4_seq_ctrl: RTL and testbench
==================================

// Module: adder4_seq_ctrl
// PURPOSE
//  Sequencer that runs one shared adder4bit instance over NIBBLES cycles to perform
//  a multi-precision add/subtract of 4*NIBBLES-bit operands, ripple-carrying between nibbles.
//  It sits between a requester (start/done handshake) and the adder4bit datapath, which it
//  instantiates internally. Result, carry and signed overflow are registered at completion.
// PARAMETERS
//  NIBBLES  4  number of 4-bit slices; operand width W = 4*NIBBLES; legal range 2..8
// PORTS
//  clk       in   1  single clock, rising edge
//  rst_n     in   1  asynchronous active-low reset
//  start     in   1  request; sampled high in IDLE or DONE launches an operation
//  sub       in   1  0: a+b, 1: a-b; sampled with start
//  a         in   W  operand A; sampled with start
//  b         in   W  operand B; sampled with start
//  busy      out  1  high while state==RUN
//  done      out  1  one-cycle pulse; result outputs valid from this cycle on
//  sum       out  W  result, held until next completion
//  carry     out  1  carry out of top nibble (sub: 1 = no borrow)
//  overflow  out  1  two's-complement overflow of the W-bit operation
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, idx=0, busy=0, done=0, sum=0, carry=0, overflow=0,
//    operand/carry registers cleared. Reset mid-RUN abandons the operation; no done is produced.
//  - FSM: IDLE -start-> RUN; RUN -(idx==NIBBLES-1)-> DONE; DONE -start-> RUN, else -> IDLE.
//  - Launch edge: opA<=a; opB<=sub ? ~b : b; cin_r<=sub; idx<=0; acc<=0.
//  - RUN, each edge: adder4bit(opA[4idx+:4], opB[4idx+:4], cin_r) -> acc[4idx+:4]<=out,
//    cin_r<=carry, idx<=idx+1. Only the adder's ports are used; no other arithmetic on data.
//  - Last RUN edge (idx==NIBBLES-1): sum<=acc with top nibble, carry<=adder carry,
//    overflow<=adder overflow of the top nibble only; state->DONE.
//  - Latency: start sampled at edge 0 -> nibble i processed at edge i+1 -> done high for the
//    cycle after edge NIBBLES. Back-to-back throughput: one op per NIBBLES+1 cycles.
//  - start while RUN: ignored (no queueing); a/b/sub changes during RUN have no effect.
//  - done and busy never high together; done is exactly one cycle unless restarted in DONE
//    (done still drops; busy rises the next cycle).
//  - idx width = clog2(NIBBLES); idx never exceeds NIBBLES-1.
//  - sum/carry/overflow change only on the final RUN edge or reset.
// CONFIGURATION
//  ADDSEQ_ZERO_FLAG_EN defined: extra output port zero (1 bit), registered with sum,
//    zero = (result == 0); reset value 0.
//  Not defined: no zero port; all other behaviour identical.
// TESTING (NIBBLES=4 unless noted; check latency and one-cycle done in every case)
//  1) a=16'h1234, b=16'h0FFF, sub=0 -> sum=16'h2233, carry=0, overflow=0, done after 4 edges.
//  2) a=16'hFFFF, b=16'h0001, sub=0 -> sum=16'h0000, carry=1, overflow=0 (zero=1 if enabled).
//  3) a=16'h7FFF, b=16'h0001, sub=0 -> sum=16'h8000, carry=0, overflow=1.
//  4) a=16'h0005, b=16'h0007, sub=1 -> sum=16'hFFFE, carry=0, overflow=0;
//     a=16'h8000, b=16'h0001, sub=1 -> sum=16'h7FFF, carry=1, overflow=1.
//  5) start pulsed at edge 2 of a running op with new operands -> ignored, first result intact;
//     start held high through DONE -> second op launches, done pulses at cycles 4 and 9.
//  6) rst_n low at edge 2 of RUN -> all outputs 0 immediately, no done; NIBBLES=2:
//     a=8'hF0, b=8'h10 -> sum=8'h00, carry=1, done after 2 edges.

Source files
------------

// File: rtl/adder4_seq_ctrl_if.sv
// Requester-side bundle for adder4_seq_ctrl: start/done handshake, operands and results.
// ADDSEQ_ZERO_FLAG_EN adds the registered zero flag.
interface adder4_seq_ctrl_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry;
  logic         overflow;
`ifdef ADDSEQ_ZERO_FLAG_EN
  logic         zero;
`endif

  modport master (
`ifdef ADDSEQ_ZERO_FLAG_EN
    input  zero,
`endif
    output start, sub, a, b,
    input  busy, done, sum, carry, overflow
  );

  modport slave (
`ifdef ADDSEQ_ZERO_FLAG_EN
    output zero,
`endif
    input  start, sub, a, b,
    output busy, done, sum, carry, overflow
  );
endinterface

// File: rtl/adder4_seq_ctrl.sv
// Multi-precision add/subtract sequencer driving one shared 4-bit adder slice per cycle.
// ADDSEQ_ZERO_FLAG_EN enables the registered zero-result flag.
module adder4bit (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_carry,
  output logic       o_overflow
);
  logic w_c3;

  // Carry chain kept in a block-local variable so the ripple is a plain sequence.
  always_comb begin
    logic c;
    c     = i_cin;
    o_sum = '0;
    w_c3  = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (k == 3) w_c3 = c;
      o_sum[k] = i_a[k] ^ i_b[k] ^ c;
      c        = (i_a[k] & i_b[k]) | (c & (i_a[k] ^ i_b[k]));
    end
    o_carry = c;
  end

  assign o_overflow = o_carry ^ w_c3;
endmodule

module adder4_seq_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  adder4_seq_ctrl_if.slave   bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [IW-1:0]  r_idx;
  logic [W-1:0]   r_opa;
  logic [W-1:0]   r_opb;
  logic [W-1:0]   r_acc;
  logic           r_cin;
  logic [W-1:0]   r_sum;
  logic           r_carry;
  logic           r_ovf;
`ifdef ADDSEQ_ZERO_FLAG_EN
  logic           r_zero;
`endif

  logic           w_launch;
  logic           w_last;
  logic [3:0]     w_nib_a;
  logic [3:0]     w_nib_b;
  logic [3:0]     w_nib_out;
  logic           w_nib_carry;
  logic           w_nib_ovf;
  logic [W-1:0]   w_result;

  assign w_launch = (r_state != S_RUN) && bus.start;
  assign w_last   = (r_state == S_RUN) && (r_idx == IW'(NIBBLES - 1));
  assign w_nib_a  = r_opa[4*r_idx +: 4];
  assign w_nib_b  = r_opb[4*r_idx +: 4];

  adder4bit u_adder (
    .i_a        (w_nib_a),
    .i_b        (w_nib_b),
    .i_cin      (r_cin),
    .o_sum      (w_nib_out),
    .o_carry    (w_nib_carry),
    .o_overflow (w_nib_ovf)
  );

  // On the final slice the top nibble is still in flight; merge it with the accumulator.
  assign w_result = {w_nib_out, r_acc[W-5:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (bus.start) w_next = S_RUN;
      S_RUN:  if (w_last)    w_next = S_DONE;
      S_DONE: w_next = bus.start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_acc   <= '0;
      r_cin   <= 1'b0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
`ifdef ADDSEQ_ZERO_FLAG_EN
      r_zero  <= 1'b0;
`endif
    end else if (w_launch) begin
      r_opa <= bus.a;
      r_opb <= bus.sub ? ~bus.b : bus.b;
      r_cin <= bus.sub;
      r_idx <= '0;
      r_acc <= '0;
    end else if (r_state == S_RUN) begin
      r_acc[4*r_idx +: 4] <= w_nib_out;
      r_cin               <= w_nib_carry;
      if (w_last) begin
        r_idx   <= '0;
        r_sum   <= w_result;
        r_carry <= w_nib_carry;
        r_ovf   <= w_nib_ovf;
`ifdef ADDSEQ_ZERO_FLAG_EN
        r_zero  <= (w_result == '0);
`endif
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign bus.busy     = (r_state == S_RUN);
  assign bus.done     = (r_state == S_DONE);
  assign bus.sum      = r_sum;
  assign bus.carry    = r_carry;
  assign bus.overflow = r_ovf;
`ifdef ADDSEQ_ZERO_FLAG_EN
  assign bus.zero     = r_zero;
`endif
endmodule

// File: tb/tb_adder4_seq_ctrl.sv
// Bench for adder4_seq_ctrl: timeline/arithmetic reference model plus directed literal checks.
module tb_adder4_seq_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  adder4_seq_ctrl_if #(.NIBBLES(4)) bus4 ();
  adder4_seq_ctrl_if #(.NIBBLES(2)) bus2 ();

  adder4_seq_ctrl #(.NIBBLES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  adder4_seq_ctrl #(.NIBBLES(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference arithmetic: {carry, overflow, result[31:0]} of a w-bit add or subtract.
  function automatic logic [33:0] ref_op(input logic [31:0] a, input logic [31:0] b,
                                         input logic sub, input int w);
    logic [31:0] m, bb;
    logic [32:0] t;
    logic        c, o, sa, sb, sr;
    m  = (32'd1 << w) - 32'd1;
    bb = sub ? (~b & m) : (b & m);
    t  = {1'b0, a & m} + {1'b0, bb} + {32'd0, sub};
    c  = t[w];
    sa = a[w-1];
    sb = b[w-1];
    sr = t[w-1];
    o  = sub ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
    return {c, o, t[31:0] & m};
  endfunction

  // Timeline model: an op takes NIBBLES edges after launch, then done for one cycle.
  bit          m_run  [2] = '{0, 0};
  int          m_rem  [2] = '{0, 0};
  bit          m_done [2] = '{0, 0};
  bit          m_zero [2] = '{0, 0};
  logic [33:0] m_res  [2] = '{34'd0, 34'd0};
  logic [33:0] m_pend [2] = '{34'd0, 34'd0};

  task automatic model_reset(input int d);
    m_run[d] = 0; m_rem[d] = 0; m_done[d] = 0; m_zero[d] = 0; m_res[d] = '0;
  endtask

  task automatic model_step(input int d, input logic st, input logic [31:0] a,
                            input logic [31:0] b, input logic sub, input int n);
    m_done[d] = 0;
    if (m_run[d]) begin
      m_rem[d]--;
      if (m_rem[d] == 0) begin
        m_run[d]  = 0;
        m_done[d] = 1;
        m_res[d]  = m_pend[d];
        m_zero[d] = (m_pend[d][31:0] == 32'd0);
      end
    end else if (st) begin
      m_run[d]  = 1;
      m_rem[d]  = n;
      m_pend[d] = ref_op(a, b, sub, 4 * n);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset(0);
    else model_step(0, bus4.start, {16'd0, bus4.a}, {16'd0, bus4.b}, bus4.sub, 4);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset(1);
    else model_step(1, bus2.start, {24'd0, bus2.a}, {24'd0, bus2.b}, bus2.sub, 2);
  end

  // Cycle-by-cycle compare of both DUTs against the model.
  always @(negedge clk) begin
    check("cyc4", {20'd0, bus4.busy, bus4.done, bus4.carry, bus4.overflow, bus4.sum},
          {20'd0, m_run[0], m_done[0], m_res[0][33], m_res[0][32], m_res[0][15:0]});
    check("cyc2", {28'd0, bus2.busy, bus2.done, bus2.carry, bus2.overflow, bus2.sum},
          {28'd0, m_run[1], m_done[1], m_res[1][33], m_res[1][32], m_res[1][7:0]});
`ifdef ADDSEQ_ZERO_FLAG_EN
    check("cyczero", {38'd0, bus4.zero, bus2.zero}, {38'd0, m_zero[0], m_zero[1]});
`endif
  end

  task automatic op4(input string nm, input logic [15:0] a, input logic [15:0] b,
                     input logic s, input logic [15:0] es, input logic ec, input logic eo);
    int cnt;
    @(negedge clk); bus4.start = 1'b1; bus4.a = a; bus4.b = b; bus4.sub = s;
    @(negedge clk); bus4.start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); cnt++;
      if (bus4.done) break;
    end
    check({nm, "_lat"}, 40'(cnt), 40'd4);
    check({nm, "_res"}, {22'd0, bus4.carry, bus4.overflow, bus4.sum}, {22'd0, ec, eo, es});
`ifdef ADDSEQ_ZERO_FLAG_EN
    check({nm, "_zero"}, {39'd0, bus4.zero}, {39'd0, es == 16'd0});
`endif
    @(negedge clk);
    check({nm, "_donelow"}, {39'd0, bus4.done}, 40'd0);
  endtask

  task automatic op2(input string nm, input logic [7:0] a, input logic [7:0] b,
                     input logic s, input logic [7:0] es, input logic ec, input logic eo);
    int cnt;
    @(negedge clk); bus2.start = 1'b1; bus2.a = a; bus2.b = b; bus2.sub = s;
    @(negedge clk); bus2.start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); cnt++;
      if (bus2.done) break;
    end
    check({nm, "_lat"}, 40'(cnt), 40'd2);
    check({nm, "_res"}, {30'd0, bus2.carry, bus2.overflow, bus2.sum}, {30'd0, ec, eo, es});
  endtask

  initial begin
    int cnt;
    logic [11:0] mask;
    logic        seen;
    bus4.start = 1'b0; bus4.sub = 1'b0; bus4.a = '0; bus4.b = '0;
    bus2.start = 1'b0; bus2.sub = 1'b0; bus2.a = '0; bus2.b = '0;
    repeat (3) @(negedge clk);
    check("reset", {20'd0, bus4.busy, bus4.done, bus4.carry, bus4.overflow, bus4.sum}, 40'd0);
    rst_n = 1'b1;
    @(negedge clk);

    op4("add1", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
    op4("add2", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    op4("add3", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    op4("sub1", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    op4("sub2", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // start pulsed mid-run with new operands must be ignored
    @(negedge clk); bus4.start = 1'b1; bus4.a = 16'h1234; bus4.b = 16'h0FFF; bus4.sub = 1'b0;
    @(negedge clk); bus4.start = 1'b0;
    @(negedge clk); bus4.start = 1'b1; bus4.a = 16'hFFFF; bus4.b = 16'hFFFF; bus4.sub = 1'b1;
    @(negedge clk); bus4.start = 1'b0;
    cnt = 2;
    for (int i = 0; i < 20; i++) begin
      if (bus4.done) break;
      @(negedge clk); cnt++;
    end
    check("ign_lat", 40'(cnt), 40'd4);
    check("ign_res", {22'd0, bus4.carry, bus4.overflow, bus4.sum}, {22'd0, 1'b0, 1'b0, 16'h2233});

    // start held through DONE relaunches immediately
    repeat (2) @(negedge clk);
    bus4.start = 1'b1; bus4.a = 16'h7FFF; bus4.b = 16'h0001; bus4.sub = 1'b0;
    mask = '0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus4.done) mask[k] = 1'b1;
      if (k == 5) bus4.start = 1'b0;
    end
    check("b2b_mask", {28'd0, mask}, 40'h210);
    check("b2b_res", {22'd0, bus4.carry, bus4.overflow, bus4.sum}, {22'd0, 1'b0, 1'b1, 16'h8000});

    // asynchronous reset in the middle of a run
    @(negedge clk); bus4.start = 1'b1; bus4.a = 16'h0005; bus4.b = 16'h0007; bus4.sub = 1'b1;
    @(negedge clk); bus4.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check("rst_mid", {20'd0, bus4.busy, bus4.done, bus4.carry, bus4.overflow, bus4.sum}, 40'd0);
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus4.done || bus4.busy) seen = 1'b1;
    end
    check("rst_nodone", {39'd0, seen}, 40'd0);

    op2("n2_a", 8'hF0, 8'h10, 1'b0, 8'h00, 1'b1, 1'b0);
    op2("n2_b", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    op2("n2_c", 8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
